// File: rtl/predictor_if.sv
// rtl/predictor_if.sv - fetcher query and ROB commit signal bundle for the branch predictor
interface predictor_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 enable_from_fetcher;
  logic [31:0]          inst_pos_from_fetcher;
  logic                 if_jump_to_fetcher;
  logic                 valid_to_fetcher;
  logic                 enable_from_rob;
  logic                 jump_result_from_rob;
  logic                 if_predicted_jumped_from_rob;
  logic [31:0]          inst_pos_from_rob;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] mispredict_cnt;

  // Driver side: issues queries and commit reports, observes predictions and statistics
  modport master (
    output enable_from_fetcher, inst_pos_from_fetcher,
    output enable_from_rob, jump_result_from_rob, if_predicted_jumped_from_rob, inst_pos_from_rob,
    input  if_jump_to_fetcher, valid_to_fetcher, branch_cnt, mispredict_cnt
  );

  // Predictor side
  modport slave (
    input  enable_from_fetcher, inst_pos_from_fetcher,
    input  enable_from_rob, jump_result_from_rob, if_predicted_jumped_from_rob, inst_pos_from_rob,
    output if_jump_to_fetcher, valid_to_fetcher, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/predictor.sv
// rtl/predictor.sv - 2-bit saturating counter branch history table with commit statistics
module predictor #(
  parameter int BHT_INDEX_WIDTH = 8,
  parameter int CNT_WIDTH       = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  predictor_if.slave bus
);
  localparam int BHT_SIZE = 1 << BHT_INDEX_WIDTH;

  logic [1:0]                 bht_q [BHT_SIZE];
  logic [1:0]                 bht_d [BHT_SIZE];
  logic                       if_jump_q, if_jump_d;
  logic                       valid_q, valid_d;
  logic [CNT_WIDTH-1:0]       branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]       mispredict_cnt_q, mispredict_cnt_d;

  logic [BHT_INDEX_WIDTH-1:0] query_idx;
  logic [BHT_INDEX_WIDTH-1:0] update_idx;
  logic [1:0]                 update_cnt;

  // Word-aligned PC bits select the entry; low and high PC bits are deliberately aliased away
  assign query_idx  = bus.inst_pos_from_fetcher[BHT_INDEX_WIDTH+1:2];
  assign update_idx = bus.inst_pos_from_rob[BHT_INDEX_WIDTH+1:2];
  assign update_cnt = bht_q[update_idx];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.inst_pos_from_fetcher[31:BHT_INDEX_WIDTH+2],
                            bus.inst_pos_from_fetcher[1:0],
                            bus.inst_pos_from_rob[31:BHT_INDEX_WIDTH+2],
                            bus.inst_pos_from_rob[1:0]};

  // Next state: prediction reads the pre-update table so a same-cycle update never bypasses into it
  always_comb begin
    bht_d            = bht_q;
    if_jump_d        = if_jump_q;
    valid_d          = 1'b0;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (bus.enable_from_fetcher) begin
      valid_d   = 1'b1;
      if_jump_d = bht_q[query_idx][1];
    end

    if (bus.enable_from_rob) begin
      if (bus.jump_result_from_rob) begin
        if (update_cnt != 2'b11) bht_d[update_idx] = update_cnt + 2'b01;
      end else begin
        if (update_cnt != 2'b00) bht_d[update_idx] = update_cnt - 2'b01;
      end
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      if (bus.jump_result_from_rob != bus.if_predicted_jumped_from_rob)
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State register: reset wins over ready; ready low freezes everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_SIZE; i++) bht_q[i] <= 2'b01;
      if_jump_q        <= 1'b0;
      valid_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (rdy_in) begin
      bht_q            <= bht_d;
      if_jump_q        <= if_jump_d;
      valid_q          <= valid_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.if_jump_to_fetcher = if_jump_q;
  assign bus.valid_to_fetcher   = valid_q;
  assign bus.branch_cnt         = branch_cnt_q;
  assign bus.mispredict_cnt     = mispredict_cnt_q;
endmodule

// File: tb/tb_predictor.sv
// tb/tb_predictor.sv - randomized and directed self-checking bench for predictor
module tb_predictor;
  localparam int BHT_INDEX_WIDTH = 8;
  localparam int CNT_WIDTH       = 32;
  localparam int ENTRIES         = 1 << BHT_INDEX_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;

  predictor_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  predictor #(
    .BHT_INDEX_WIDTH(BHT_INDEX_WIDTH),
    .CNT_WIDTH      (CNT_WIDTH)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integer strength per entry, clamped to 0..3
  int        m_strength [ENTRIES];
  bit        m_jump;
  bit        m_valid;
  longint    m_branches;
  longint    m_mispredicts;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int entry_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  // One clock cycle: drive inputs, advance the model by the same edge, compare all outputs
  task automatic step(input bit r, input bit rd, input bit ef, input logic [31:0] fpc,
                      input bit er, input bit res, input bit prd, input logic [31:0] rpc);
    rst = r;
    rdy = rd;
    bus.enable_from_fetcher          = ef;
    bus.inst_pos_from_fetcher        = fpc;
    bus.enable_from_rob              = er;
    bus.jump_result_from_rob         = res;
    bus.if_predicted_jumped_from_rob = prd;
    bus.inst_pos_from_rob            = rpc;

    if (r) begin
      for (int i = 0; i < ENTRIES; i++) m_strength[i] = 1;
      m_jump = 0; m_valid = 0; m_branches = 0; m_mispredicts = 0;
    end else if (rd) begin
      m_valid = ef;
      if (ef) m_jump = (m_strength[entry_of(fpc)] >= 2);
      if (er) begin
        if (res) m_strength[entry_of(rpc)] = (m_strength[entry_of(rpc)] == 3) ? 3 : m_strength[entry_of(rpc)] + 1;
        else     m_strength[entry_of(rpc)] = (m_strength[entry_of(rpc)] == 0) ? 0 : m_strength[entry_of(rpc)] - 1;
        m_branches++;
        if (res != prd) m_mispredicts++;
      end
    end

    @(posedge clk);
    #1;
    check("valid", 64'(bus.valid_to_fetcher), 64'(m_valid));
    check("jump", 64'(bus.if_jump_to_fetcher), 64'(m_jump));
    check("branch_cnt", 64'(bus.branch_cnt), 64'(m_branches % (64'd1 << CNT_WIDTH)));
    check("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(m_mispredicts % (64'd1 << CNT_WIDTH)));
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic query(input logic [31:0] pc);
    step(0, 1, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input bit res, input bit prd);
    step(0, 1, 0, 0, 1, res, prd, pc);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 4))
      0: return 32'h0000_1000;
      1: return 32'h0000_1400;
      2: return 32'h0000_1004;
      3: return 32'h0000_1000 | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.enable_from_fetcher          = 0;
    bus.inst_pos_from_fetcher        = 0;
    bus.enable_from_rob              = 0;
    bus.jump_result_from_rob         = 0;
    bus.if_predicted_jumped_from_rob = 0;
    bus.inst_pos_from_rob            = 0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("rst_valid", 64'(bus.valid_to_fetcher), 64'd0);
    check("rst_branch_cnt", 64'(bus.branch_cnt), 64'd0);

    // Fresh entry predicts not-taken, valid one cycle after query, valid drops when idle
    query(32'h0000_1000);
    check("q_fresh_valid", 64'(bus.valid_to_fetcher), 64'd1);
    check("q_fresh_jump", 64'(bus.if_jump_to_fetcher), 64'd0);
    idle();
    check("idle_valid", 64'(bus.valid_to_fetcher), 64'd0);

    // One taken update moves 01 -> 10
    update(32'h0000_1000, 1, 0);
    query(32'h0000_1000);
    check("q_after_taken", 64'(bus.if_jump_to_fetcher), 64'd1);
    idle();
    check("hold_jump", 64'(bus.if_jump_to_fetcher), 64'd1);

    // Three not-taken updates saturate at 00
    for (int i = 0; i < 3; i++) update(32'h0000_1000, 0, 1);
    query(32'h0000_1000);
    check("q_sat_low", 64'(bus.if_jump_to_fetcher), 64'd0);
    update(32'h0000_1000, 1, 0);
    query(32'h0000_1000);
    check("q_sat_low_one_up", 64'(bus.if_jump_to_fetcher), 64'd0);

    // Same-cycle query and update to the same index sees the old value
    do_reset();
    step(0, 1, 1, 32'h0000_1000, 1, 1, 0, 32'h0000_1000);
    check("same_cycle_old", 64'(bus.if_jump_to_fetcher), 64'd0);
    query(32'h0000_1000);
    check("same_cycle_next", 64'(bus.if_jump_to_fetcher), 64'd1);

    // Aliasing PCs share an entry; neighbour word does not
    do_reset();
    update(32'h0000_1000, 1, 0);
    update(32'h0000_1000, 1, 0);
    step(0, 1, 1, 32'h0000_1400, 1, 0, 0, 32'h0000_2000);
    check("alias_1400", 64'(bus.if_jump_to_fetcher), 64'd1);
    query(32'h0000_1004);
    check("neighbour_1004", 64'(bus.if_jump_to_fetcher), 64'd0);

    // Statistics, then ready low with commit asserted must not count
    do_reset();
    update(32'h0000_2000, 1, 1);
    update(32'h0000_2000, 0, 1);
    update(32'h0000_2004, 0, 0);
    update(32'h0000_2008, 1, 0);
    update(32'h0000_2000, 1, 1);
    check("stats_branches", 64'(bus.branch_cnt), 64'd5);
    check("stats_mispredicts", 64'(bus.mispredict_cnt), 64'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0000_2000, 1, 1, 0, 32'h0000_2000);
    check("frozen_branches", 64'(bus.branch_cnt), 64'd5);
    check("frozen_mispredicts", 64'(bus.mispredict_cnt), 64'd2);

    // Reset beats ready low and discards training
    update(32'h0000_1000, 1, 0);
    update(32'h0000_1000, 1, 0);
    query(32'h0000_1000);
    check("trained", 64'(bus.if_jump_to_fetcher), 64'd1);
    step(1, 0, 1, 32'h0000_1000, 1, 1, 0, 32'h0000_1000);
    check("rst_rdy0_jump", 64'(bus.if_jump_to_fetcher), 64'd0);
    check("rst_rdy0_valid", 64'(bus.valid_to_fetcher), 64'd0);
    check("rst_rdy0_branches", 64'(bus.branch_cnt), 64'd0);
    query(32'h0000_1000);
    check("post_rst_pred", 64'(bus.if_jump_to_fetcher), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0,
           1'($urandom_range(0, 1)), pick_pc(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_pc());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
